engine_cmd_router: RTL and testbench

- Parametrised N-engine command router/arbiter that replaces hard-wired per-engine stream plumbing between the command controller and the verification engines.
- Ingress: steers each packet from the command stream to one of NUM_ENG engine channels, selected by an engine-ID field in the packet's first beat.
- Egress: merges engine response packets back into one stream using packet-level round-robin.
- Sits in the interface clock domain, upstream of the per-engine CDC FIFOs.

---
 rtl/engine_cmd_router.sv | 207 ++++++++++++++++++++
 tb/tb_engine_cmd_router.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_cmd_router.sv
// Command router: steers ingress packets to engines by ID field,
// merges engine responses back with packet-level round-robin.
module engine_cmd_router #(
  parameter int NUM_ENG     = 4,
  parameter int DAT_BYTS    = 8,
  parameter int ENG_SEL_LSB = 24,
  parameter int ENG_BITS    = $clog2(NUM_ENG),
  localparam int DAT_BITS   = DAT_BYTS * 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DAT_BITS-1:0]         i_rx_dat,
  input  logic                        i_rx_val,
  input  logic                        i_rx_sop,
  input  logic                        i_rx_eop,
  output logic                        o_rx_rdy,
  input  logic [NUM_ENG-1:0]          i_eng_enb,
  output logic [DAT_BITS-1:0]         o_eng_dat,
  output logic                        o_eng_sop,
  output logic                        o_eng_eop,
  output logic [NUM_ENG-1:0]          o_eng_val,
  input  logic [NUM_ENG-1:0]          i_eng_rdy,
  input  logic [NUM_ENG*DAT_BITS-1:0] i_rsp_dat,
  input  logic [NUM_ENG-1:0]          i_rsp_val,
  input  logic [NUM_ENG-1:0]          i_rsp_sop,
  input  logic [NUM_ENG-1:0]          i_rsp_eop,
  output logic [NUM_ENG-1:0]          o_rsp_rdy,
  output logic [DAT_BITS-1:0]         o_tx_dat,
  output logic                        o_tx_val,
  output logic                        o_tx_sop,
  output logic                        o_tx_eop,
  input  logic                        i_tx_rdy,
  output logic [15:0]                 o_drop_cnt,
  output logic                        o_drop_pls
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [7:0] NUM_ENG8 = 8'(NUM_ENG);

  logic [1:0]          ist_q, ist_d;
  logic [ENG_BITS-1:0] sel_q, sel_d;
  logic [15:0]         cnt_q;
  logic                pls_q;

  logic [7:0]          id;
  logic [ENG_BITS-1:0] eid;
  logic                id_ok;
  logic [ENG_BITS-1:0] cur;
  logic                fwd;
  logic                rdy;
  logic                drop_evt;

  assign id    = i_rx_dat[ENG_SEL_LSB +: 8];
  assign eid   = id[ENG_BITS-1:0];
  assign id_ok = (id < NUM_ENG8) && i_eng_enb[eid];

  always_comb begin
    ist_d    = ist_q;
    sel_d    = sel_q;
    cur      = sel_q;
    fwd      = 1'b0;
    rdy      = 1'b0;
    drop_evt = 1'b0;
    unique case (ist_q)
      IDLE: begin
        if (i_rx_val) begin
          if (i_rx_sop && id_ok) begin
            cur = eid;
            fwd = 1'b1;
            rdy = i_eng_rdy[eid];
            if (rdy) begin
              sel_d = eid;
              if (!i_rx_eop) ist_d = FWD;
            end
          end else begin
            // bad ID, disabled engine, or stray beat: swallow it
            rdy      = 1'b1;
            drop_evt = 1'b1;
            if (i_rx_sop && !i_rx_eop) ist_d = DROP;
          end
        end
      end
      FWD: begin
        fwd = 1'b1;
        rdy = i_eng_rdy[sel_q];
        if (i_rx_val && rdy && i_rx_eop) ist_d = IDLE;
      end
      DROP: begin
        rdy = 1'b1;
        if (i_rx_val && i_rx_eop) ist_d = IDLE;
      end
      default: ist_d = IDLE;
    endcase
  end

  assign o_rx_rdy  = rdy;
  assign o_eng_dat = i_rx_dat;
  assign o_eng_sop = i_rx_sop;
  assign o_eng_eop = i_rx_eop;

  always_comb begin
    o_eng_val = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      o_eng_val[k] = fwd && i_rx_val && (cur == ENG_BITS'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ist_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      pls_q <= 1'b0;
    end else begin
      ist_q <= ist_d;
      sel_q <= sel_d;
      pls_q <= drop_evt;
      if (drop_evt && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = cnt_q;
  assign o_drop_pls = pls_q;

  logic [0:0]          est_q, est_d;
  logic [ENG_BITS-1:0] ptr_q, ptr_d;
  logic [ENG_BITS-1:0] gnt_q, gnt_d;
  logic                cand;
  logic [ENG_BITS-1:0] cidx;
  logic [ENG_BITS-1:0] g;
  logic [ENG_BITS-1:0] nxt;
  logic                act;
  logic                tx_xfer;

  // first sop-valid engine at or after ptr, wrapping
  always_comb begin
    int j;
    cand = 1'b0;
    cidx = '0;
    j    = 0;
    for (int i = 0; i < NUM_ENG; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_ENG) j = j - NUM_ENG;
      if (!cand && i_rsp_val[j] && i_rsp_sop[j]) begin
        cand = 1'b1;
        cidx = ENG_BITS'(j);
      end
    end
  end

  assign g   = (est_q == LOCK) ? gnt_q : cidx;
  assign act = (est_q == LOCK) || cand;
  assign nxt = (g == ENG_BITS'(NUM_ENG - 1)) ? '0 : g + 1'b1;

  always_comb begin
    o_tx_dat  = '0;
    o_tx_val  = 1'b0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_rsp_rdy = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (act && g == ENG_BITS'(k)) begin
        o_tx_dat     = i_rsp_dat[k*DAT_BITS +: DAT_BITS];
        o_tx_val     = i_rsp_val[k];
        o_tx_sop     = i_rsp_sop[k];
        o_tx_eop     = i_rsp_eop[k];
        o_rsp_rdy[k] = i_tx_rdy;
      end
    end
  end

  assign tx_xfer = o_tx_val && i_tx_rdy;

  always_comb begin
    est_d = est_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    if (tx_xfer) begin
      if (o_tx_eop) begin
        ptr_d = nxt;
        est_d = ARB;
      end else if (est_q == ARB) begin
        gnt_d = g;
        est_d = LOCK;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      est_q <= ARB;
      ptr_q <= '0;
      gnt_q <= '0;
    end else begin
      est_q <= est_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

endmodule

// File: tb/tb_engine_cmd_router.sv
// Directed bench for engine_cmd_router: ingress routing/drops,
// egress round-robin, stalls, reset recovery, counter saturation.
module tb_engine_cmd_router;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [63:0]  i_rx_dat;
  logic         i_rx_val, i_rx_sop, i_rx_eop;
  logic         o_rx_rdy;
  logic [3:0]   i_eng_enb;
  logic [63:0]  o_eng_dat;
  logic         o_eng_sop, o_eng_eop;
  logic [3:0]   o_eng_val;
  logic [3:0]   i_eng_rdy;
  logic [255:0] i_rsp_dat;
  logic [3:0]   i_rsp_val, i_rsp_sop, i_rsp_eop;
  logic [3:0]   o_rsp_rdy;
  logic [63:0]  o_tx_dat;
  logic         o_tx_val, o_tx_sop, o_tx_eop;
  logic         i_tx_rdy;
  logic [15:0]  o_drop_cnt;
  logic         o_drop_pls;

  engine_cmd_router dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_dat(i_rx_dat), .i_rx_val(i_rx_val),
    .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop),
    .o_rx_rdy(o_rx_rdy), .i_eng_enb(i_eng_enb),
    .o_eng_dat(o_eng_dat), .o_eng_sop(o_eng_sop),
    .o_eng_eop(o_eng_eop), .o_eng_val(o_eng_val),
    .i_eng_rdy(i_eng_rdy), .i_rsp_dat(i_rsp_dat),
    .i_rsp_val(i_rsp_val), .i_rsp_sop(i_rsp_sop),
    .i_rsp_eop(i_rsp_eop), .o_rsp_rdy(o_rsp_rdy),
    .o_tx_dat(o_tx_dat), .o_tx_val(o_tx_val),
    .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
    .i_tx_rdy(i_tx_rdy), .o_drop_cnt(o_drop_cnt),
    .o_drop_pls(o_drop_pls)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  int         rlen [4];
  int         rpos [4];
  logic [3:0] fire;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rxb(input logic [7:0] id, input logic [15:0] tg,
                     input logic s, input logic e);
    i_rx_dat = {16'hBEEF, tg, id, 24'h00ABCD};
    i_rx_val = 1'b1;
    i_rx_sop = s;
    i_rx_eop = e;
  endtask

  task automatic rx_idle();
    i_rx_val = 1'b0;
    i_rx_sop = 1'b0;
    i_rx_eop = 1'b0;
    i_rx_dat = '0;
  endtask

  function automatic logic [63:0] rd(input int k, input int p);
    return 64'hA5A5_0000_0000_0000 | 64'(k << 8) | 64'(p);
  endfunction

  task automatic post(input int k, input int len);
    rlen[k] = len;
    rpos[k] = 0;
  endtask

  task automatic rsp_drive();
    for (int k = 0; k < 4; k++) begin
      if (fire[k]) rpos[k]++;
      i_rsp_val[k] = rpos[k] < rlen[k];
      i_rsp_sop[k] = rpos[k] == 0;
      i_rsp_eop[k] = rpos[k] == rlen[k] - 1;
      i_rsp_dat[k*64 +: 64] = rd(k, rpos[k]);
    end
    fire = '0;
  endtask

  task automatic eg(input logic rdy, input logic ev,
                    input logic [63:0] edat, input logic [3:0] err);
    step();
    rsp_drive();
    i_tx_rdy = rdy;
    #4;
    check("tx_val", 64'(o_tx_val), 64'(ev));
    if (ev) check("tx_dat", o_tx_dat, edat);
    check("rsp_rdy", 64'(o_rsp_rdy), 64'(err));
    fire = o_rsp_rdy & i_rsp_val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    rx_idle();
    i_eng_enb = 4'hF;
    i_eng_rdy = 4'hF;
    i_rsp_dat = '0;
    i_rsp_val = '0;
    i_rsp_sop = '0;
    i_rsp_eop = '0;
    i_tx_rdy  = 1'b0;
    fire      = '0;
    for (int k = 0; k < 4; k++) begin
      rlen[k] = 0;
      rpos[k] = 0;
    end
    step();
    step();
    i_rst = 1'b0;
    #4;
    check("rst_rx_rdy", 64'(o_rx_rdy), 0);
    check("rst_eng_val", 64'(o_eng_val), 0);
    check("rst_tx_val", 64'(o_tx_val), 0);
    check("rst_rsp_rdy", 64'(o_rsp_rdy), 0);
    check("rst_cnt", 64'(o_drop_cnt), 0);
    check("rst_pls", 64'(o_drop_pls), 0);

    // 3-beat to engine 2; later beats carry other IDs / mask
    step(); rxb(8'd2, 16'h1, 1, 0); #4;
    check("p2_val0", 64'(o_eng_val), 64'h4);
    check("p2_dat0", o_eng_dat, i_rx_dat);
    check("p2_rdy0", 64'(o_rx_rdy), 1);
    check("p2_sop0", 64'(o_eng_sop), 1);
    step(); rxb(8'd7, 16'h2, 0, 0); #4;
    check("p2_val1", 64'(o_eng_val), 64'h4);
    check("p2_dat1", o_eng_dat, i_rx_dat);
    step(); i_eng_enb = 4'b1011; rxb(8'd0, 16'h3, 0, 1); #4;
    check("p2_val2", 64'(o_eng_val), 64'h4);
    check("p2_eop2", 64'(o_eng_eop), 1);
    step(); rx_idle(); i_eng_enb = 4'hF; #4;
    check("p2_val_end", 64'(o_eng_val), 0);
    check("p2_cnt", 64'(o_drop_cnt), 0);
    check("p2_pls", 64'(o_drop_pls), 0);

    // bad ID then disabled engine
    step(); rxb(8'd5, 16'h10, 1, 0); #4;
    check("d5_rdy0", 64'(o_rx_rdy), 1);
    check("d5_val0", 64'(o_eng_val), 0);
    step(); rxb(8'd5, 16'h11, 0, 1); #4;
    check("d5_pls", 64'(o_drop_pls), 1);
    check("d5_cnt", 64'(o_drop_cnt), 1);
    check("d5_rdy1", 64'(o_rx_rdy), 1);
    check("d5_val1", 64'(o_eng_val), 0);
    step(); i_eng_enb = 4'b1101; rxb(8'd1, 16'h12, 1, 0); #4;
    check("d1_rdy0", 64'(o_rx_rdy), 1);
    check("d1_val0", 64'(o_eng_val), 0);
    check("d1_pls0", 64'(o_drop_pls), 0);
    step(); i_eng_enb = 4'hF; rxb(8'd1, 16'h13, 0, 1); #4;
    check("d1_pls1", 64'(o_drop_pls), 1);
    check("d1_cnt", 64'(o_drop_cnt), 2);
    check("d1_val1", 64'(o_eng_val), 0);
    step(); rx_idle(); #4;
    check("d_pls_end", 64'(o_drop_pls), 0);
    check("d_cnt_end", 64'(o_drop_cnt), 2);

    // single-beat id0 then 2-beat id3 with stall
    step(); rxb(8'd0, 16'h20, 1, 1); #4;
    check("s0_val", 64'(o_eng_val), 64'h1);
    check("s0_rdy", 64'(o_rx_rdy), 1);
    step(); rxb(8'd3, 16'h21, 1, 0); #4;
    check("s3_val0", 64'(o_eng_val), 64'h8);
    check("s3_rdy0", 64'(o_rx_rdy), 1);
    step(); i_eng_rdy = 4'b0111; rxb(8'd3, 16'h22, 0, 1); #4;
    check("s3_rdy_stall", 64'(o_rx_rdy), 0);
    check("s3_val_stall", 64'(o_eng_val), 64'h8);
    step(); i_eng_rdy = 4'hF; #4;
    check("s3_rdy1", 64'(o_rx_rdy), 1);
    check("s3_val1", 64'(o_eng_val), 64'h8);
    step(); rx_idle(); #4;
    check("s3_val_end", 64'(o_eng_val), 0);
    check("s3_cnt", 64'(o_drop_cnt), 2);

    // egress: 0,1,3 with 2 beats each
    post(0, 2); post(1, 2); post(3, 2);
    eg(1, 1, rd(0, 0), 4'b0001);
    eg(1, 1, rd(0, 1), 4'b0001);
    eg(1, 1, rd(1, 0), 4'b0010);
    eg(1, 1, rd(1, 1), 4'b0010);
    eg(1, 1, rd(3, 0), 4'b1000);
    eg(1, 1, rd(3, 1), 4'b1000);
    eg(1, 0, 64'h0, 4'b0000);
    post(0, 2); post(3, 2);
    eg(1, 1, rd(0, 0), 4'b0001);
    eg(1, 1, rd(0, 1), 4'b0001);
    eg(1, 1, rd(3, 0), 4'b1000);
    eg(1, 1, rd(3, 1), 4'b1000);
    eg(1, 0, 64'h0, 4'b0000);

    // engine 2 stalled mid-packet while 0 and 1 wait
    post(2, 3);
    eg(1, 1, rd(2, 0), 4'b0100);
    post(0, 1); post(1, 1);
    for (int c = 0; c < 5; c++) eg(0, 1, rd(2, 1), 4'b0000);
    eg(1, 1, rd(2, 1), 4'b0100);
    eg(1, 1, rd(2, 2), 4'b0100);
    eg(1, 1, rd(0, 0), 4'b0001);
    eg(1, 1, rd(1, 0), 4'b0010);
    eg(1, 0, 64'h0, 4'b0000);

    // reset in the middle of a forwarded packet
    step(); rxb(8'd1, 16'h30, 1, 0); #4;
    check("r_val0", 64'(o_eng_val), 64'h2);
    step(); rxb(8'd1, 16'h31, 0, 0); #4;
    check("r_val1", 64'(o_eng_val), 64'h2);
    step(); rx_idle(); i_rst = 1'b1; #4;
    check("r_cnt_rst", 64'(o_drop_cnt), 0);
    step(); i_rst = 1'b0; rxb(8'd1, 16'h32, 0, 0); #4;
    check("r_stray_rdy", 64'(o_rx_rdy), 1);
    check("r_stray_val", 64'(o_eng_val), 0);
    step(); rxb(8'd1, 16'h33, 0, 1); #4;
    check("r_pls1", 64'(o_drop_pls), 1);
    check("r_cnt1", 64'(o_drop_cnt), 1);
    check("r_val3", 64'(o_eng_val), 0);
    step(); rxb(8'd1, 16'h34, 1, 1); #4;
    check("r_pls2", 64'(o_drop_pls), 1);
    check("r_cnt2", 64'(o_drop_cnt), 2);
    check("r_new_val", 64'(o_eng_val), 64'h2);
    check("r_new_rdy", 64'(o_rx_rdy), 1);
    step(); rx_idle(); #4;
    check("r_pls_end", 64'(o_drop_pls), 0);
    check("r_cnt_end", 64'(o_drop_cnt), 2);

    // saturate the drop counter with stray beats
    step(); i_rst = 1'b1;
    step(); i_rst = 1'b0; rxb(8'd0, 16'h40, 0, 0); #4;
    check("sat_cnt0", 64'(o_drop_cnt), 0);
    repeat (65534) step();
    #4;
    check("sat_fffe", 64'(o_drop_cnt), 64'hFFFE);
    check("sat_pls", 64'(o_drop_pls), 1);
    repeat (3) step();
    #4;
    check("sat_ffff", 64'(o_drop_cnt), 64'hFFFF);
    check("sat_pls2", 64'(o_drop_pls), 1);
    step(); rx_idle();
    step(); #4;
    check("sat_hold", 64'(o_drop_cnt), 64'hFFFF);
    check("sat_pls_end", 64'(o_drop_pls), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
